// File: rtl/partition_err_meter_if.sv
// Sample stream from the sweep driver into partition_err_meter.
// One sample transfers on each rising edge where s_valid && s_ready; the driver
// holds s_idx/s_exact/s_approx stable while s_valid is high and s_ready is low.
interface partition_err_meter_if #(
   parameter int IN_W  = 7,
   parameter int OUT_W = 4
);
   logic             s_valid;
   logic             s_ready;
   logic [IN_W-1:0]  s_idx;
   logic [OUT_W-1:0] s_exact;
   logic [OUT_W-1:0] s_approx;

   modport master (output s_valid, s_idx, s_exact, s_approx, input s_ready);
   modport slave  (input s_valid, s_idx, s_exact, s_approx, output s_ready);
endinterface

// File: rtl/partition_err_meter.sv
// Error-metric collector for an exhaustively swept logic partition.
// Define ERR_METER_MSE_EN to add the squared-error accumulator output sq_sum.
module partition_err_meter #(
   parameter int IN_W  = 7,
   parameter int OUT_W = 4,
   localparam int CNT_W = IN_W + 1,
   localparam int PC_W  = $clog2(OUT_W + 1),
   localparam int HAM_W = IN_W + PC_W,
   localparam int SQ_W  = IN_W + 2 * OUT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   partition_err_meter_if.slave  s,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      err_cnt,
   output logic [HAM_W-1:0]      ham_sum,
   output logic [OUT_W-1:0]      max_abs,
`ifdef ERR_METER_MSE_EN
   output logic [SQ_W-1:0]       sq_sum,
`endif
   output logic                  seq_err,
   output logic [1:0]            fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << IN_W) - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IN_W-1:0]  IDX_ONE  = IN_W'(1);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [IN_W-1:0]    exp_idx_q;

   logic               ready;
   logic               hs;
   logic               clear;
   logic               last_hs;
   logic               mismatch;
   logic [OUT_W-1:0]   diff_bits;
   logic [PC_W-1:0]    ham_d;
   logic [OUT_W-1:0]   abs_d;
`ifdef ERR_METER_MSE_EN
   logic [2*OUT_W-1:0] sq_d;
`endif

   function automatic logic [PC_W-1:0] popcount(input logic [OUT_W-1:0] v);
      logic [PC_W-1:0] acc;
      acc = '0;
      for (int k = 0; k < OUT_W; k++) begin
         acc = acc + PC_W'(v[k]);
      end
      return acc;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            ready = 1'b1;
            busy  = 1'b1;
            if (last_hs) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign s.s_ready = ready;
   assign fsm_state = state_q;
   assign hs        = s.s_valid && ready;
   assign clear     = (state_q == IDLE) && start;
   // The sweep ends on the handshake that brings the sample count to 2^IN_W.
   assign last_hs   = hs && (cnt_q == LAST_CNT);

   always_comb begin
      mismatch  = (s.s_exact != s.s_approx);
      diff_bits = s.s_exact ^ s.s_approx;
      ham_d     = popcount(diff_bits);
      abs_d     = (s.s_exact >= s.s_approx) ? (s.s_exact - s.s_approx)
                                            : (s.s_approx - s.s_exact);
`ifdef ERR_METER_MSE_EN
      sq_d      = {{OUT_W{1'b0}}, abs_d} * {{OUT_W{1'b0}}, abs_d};
`endif
   end

   // Summary registers double as the outputs, so they hold between sweeps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         exp_idx_q <= '0;
         err_cnt   <= '0;
         ham_sum   <= '0;
         max_abs   <= '0;
         seq_err   <= 1'b0;
`ifdef ERR_METER_MSE_EN
         sq_sum    <= '0;
`endif
      end else if (clear) begin
         cnt_q     <= '0;
         exp_idx_q <= '0;
         err_cnt   <= '0;
         ham_sum   <= '0;
         max_abs   <= '0;
         seq_err   <= 1'b0;
`ifdef ERR_METER_MSE_EN
         sq_sum    <= '0;
`endif
      end else if (hs) begin
         cnt_q     <= cnt_q + CNT_ONE;
         exp_idx_q <= exp_idx_q + IDX_ONE;
         err_cnt   <= err_cnt + CNT_W'(mismatch);
         ham_sum   <= ham_sum + HAM_W'(ham_d);
         if (abs_d > max_abs) max_abs <= abs_d;
         if (s.s_idx != exp_idx_q) seq_err <= 1'b1;
`ifdef ERR_METER_MSE_EN
         sq_sum    <= sq_sum + SQ_W'(sq_d);
`endif
      end
   end

endmodule

// File: doc/partition_err_meter.md
Name: partition_err_meter

Overview:
- Hardware response collector for an exhaustively swept logic partition (e.g. a 7-input, 4-output multiplier slice).
- It is the consuming end of the sweep: a stimulus driver applies every input pattern 0..2^IN_W-1 in order and presents both the exact output and the approximated output for that pattern.
- The block accepts these samples over a valid/ready stream and accumulates error metrics.
- At the end of the sweep it posts a summary with a one-cycle done pulse; approximation flows use this summary in place of a printed truth-table dump.

Parameters:
- IN_W, 7: partition input count; sweep length is 2^IN_W samples.
- OUT_W, 4: partition output count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a sweep when in IDLE; ignored otherwise.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- s_idx  in  IN_W  input pattern index of the sample.
- s_exact  in  OUT_W  golden partition output.
- s_approx  in  OUT_W  approximate partition output.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse, summary valid.
- err_cnt  out  IN_W+1  number of samples with s_exact != s_approx.
- ham_sum  out  IN_W+$clog2(OUT_W+1)  total Hamming distance over the sweep.
- max_abs  out  OUT_W  maximum |s_exact - s_approx|, unsigned.
- seq_err  out  1  sticky flag: some s_idx did not match the expected index.

Behaviour:
- Reset is asynchronous, active-low, with rst_n as the single reset. Every output and accumulator resets to 0, the expected index resets to 0, and the state resets to IDLE.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - s_ready=0, busy=0.
  - start=1 clears err_cnt, ham_sum, max_abs, seq_err and the expected index to 0, then moves to RUN on the next edge.
  - Summary outputs hold their last values until that start.
- RUN:
  - s_ready=1, busy=1.
  - On each handshake, with e = s_exact, a = s_approx:
    - err_cnt += (e != a).
    - ham_sum += popcount(e ^ a).
    - d = (e >= a) ? e - a : a - e; max_abs = max(max_abs, d).
    - If s_idx != expected index, seq_err <= 1. The sample is still accumulated.
    - The expected index increments and wraps at 2^IN_W.
  - All updates are registered and visible the cycle after the handshake.
  - A sample counter of width IN_W+1 counts handshakes. The handshake that brings it to 2^IN_W moves the FSM to DONE.
  - start in RUN is ignored.
  - s_valid=0 stalls with no state change; there is no timeout.
- DONE:
  - Lasts exactly one cycle: done=1, s_ready=0, busy=0.
  - Unconditional return to IDLE.
  - Latency from the last handshake edge to done is 1 cycle. Outputs already hold final values when done is high.
- Width rules: the accumulators cannot overflow by construction. err_cnt max is 2^IN_W, and ham_sum max is 2^IN_W*OUT_W.
- Boundaries:
  - start together with rst_n low: reset wins.
  - start asserted during the DONE cycle: ignored. It must be re-asserted in IDLE.
  - rst_n low mid-sweep: immediate abort, all values 0, IDLE. A following start runs a complete fresh sweep.
  - Samples presented while s_ready=0 are not consumed.

Optional Feature:
- Macro: ERR_METER_MSE_EN.
- When defined:
  - Adds output sq_sum, width IN_W+2*OUT_W, reset to 0 and cleared on start.
  - Accumulates d*d per handshake with the same timing as ham_sum.
  - Final value is valid with done.
- When undefined: port and logic are absent, and all other behaviour is identical.

Test Plan:
All cases use IN_W=7, OUT_W=4.
1. start; 128 in-order samples with s_approx == s_exact (exact product table) -> done once, 1 cycle after the 128th handshake; err_cnt=0, ham_sum=0, max_abs=0, seq_err=0; sq_sum=0 if MSE enabled.
2. 128 in-order samples with s_approx = s_exact ^ 4'b0001 -> err_cnt=128, ham_sum=128, max_abs=1; sq_sum=128 if enabled.
3. All samples equal except idx 37: exact 4'b1001, approx 4'b0110 -> err_cnt=1, ham_sum=4, max_abs=3; sq_sum=9 if enabled.
4. Test 2 with s_valid toggled every other cycle, plus start pulsed in RUN -> identical results to test 2; done after exactly 128 handshakes; s_ready=0 in IDLE and DONE.
5. Indices 5 and 6 swapped, data otherwise exact -> seq_err=1, err_cnt=0, done after 128 handshakes.
6. rst_n pulled low after 60 handshakes -> all outputs 0 asynchronously, state IDLE; a new start with the test-3 data then yields err_cnt=1, ham_sum=4, max_abs=3.
